// File: rtl/full_adder_bit.sv
// ----------------------------------------------------------------------------
// full_adder_bit
// Purely combinational 1-bit full adder cell. This is the leaf of the ripple
// chain in full_adder.
//
// Ports:
//   a    : addend bit A
//   b    : addend bit B
//   cin  : carry in from the previous (less significant) cell
//   s    : sum bit,   a ^ b ^ cin
//   cout : carry out, majority(a, b, cin)
// ----------------------------------------------------------------------------
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// Registered WIDTH-bit ripple-carry adder: {carry, sum} = a + b + c, with the
// result and a valid qualifier registered on clk (latency exactly 1 cycle).
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset; clears sum, carry and out_valid
//   in_valid  : a, b, c carry an operation this cycle
//   a, b      : WIDTH-bit unsigned addends
//   c         : carry in
//   out_valid : sum/carry hold the result of the operation accepted on the
//               previous edge
//   sum       : registered a + b + c modulo 2^WIDTH
//   carry     : registered bit WIDTH of a + b + c
//
// Valid semantics: there is no ready. Every edge with in_valid=1 (and
// rst_n=1) accepts an operation, and the next cycle shows its result with
// out_valid=1. An edge with in_valid=0 leaves sum/carry unchanged and drops
// out_valid; operand values are ignored in that case.
// ----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // k[i] is the carry into bit i; k[0] is the external carry-in and
    // k[WIDTH] is the carry-out of the whole chain.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] s_w;

    assign k[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (k[i]),
            .s    (s_w[i]),
            .cout (k[i+1])
        );
    end

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             carry_d, carry_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = s_w;
            carry_d     = k[WIDTH];
            out_valid_d = 1'b1;
        end
    end

    // Reset wins over an operation presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       c;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;

    logic       ov1, carry1;
    logic [0:0] sum1;
    logic       ov8, carry8;
    logic [7:0] sum8;

    int total = 0;
    int bad   = 0;

    // Reference model state: value of each DUT's outputs after the last edge.
    logic       m1_valid, m1_carry;
    logic [0:0] m1_sum;
    logic       m8_valid, m8_carry;
    logic [7:0] m8_sum;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .c(c),
        .out_valid(ov1), .sum(sum1), .carry(carry1)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a8), .b(b8), .c(c),
        .out_valid(ov8), .sum(sum8), .carry(carry8)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model with
    // plain arithmetic and compare both DUTs against it.
    task automatic step(input logic rn, input logic iv, input logic [7:0] av,
                        input logic [7:0] bv, input logic cv);
        int r1, r8;
        @(negedge clk);
        rst_n = rn; in_valid = iv; a8 = av; b8 = bv;
        a1 = av[0:0]; b1 = bv[0:0]; c = cv;
        @(posedge clk);
        #1;
        if (!rn) begin
            m1_valid = 0; m1_sum = '0; m1_carry = 0;
            m8_valid = 0; m8_sum = '0; m8_carry = 0;
        end else if (iv) begin
            r1 = int'(av[0]) + int'(bv[0]) + int'(cv);
            r8 = int'(av) + int'(bv) + int'(cv);
            m1_valid = 1; m1_sum = 1'(r1 % 2);   m1_carry = (r1 >= 2);
            m8_valid = 1; m8_sum = 8'(r8 % 256); m8_carry = (r8 >= 256);
        end else begin
            m1_valid = 0;
            m8_valid = 0;
        end
        chk("w1_valid", 16'(ov1),    16'(m1_valid));
        chk("w1_sum",   16'(sum1),   16'(m1_sum));
        chk("w1_carry", 16'(carry1), 16'(m1_carry));
        chk("w8_valid", 16'(ov8),    16'(m8_valid));
        chk("w8_sum",   16'(sum8),   16'(m8_sum));
        chk("w8_carry", 16'(carry8), 16'(m8_carry));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] tt [8];
        tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n = 0; in_valid = 0; a1 = '0; b1 = '0; a8 = '0; b8 = '0; c = 0;

        // Reset held two cycles with a live operation presented.
        step(0, 1, 8'h01, 8'h01, 1);
        step(0, 1, 8'h01, 8'h01, 1);
        chk("rst_valid_const", 16'(ov8), 16'h0);
        chk("rst_sum_const",   16'(sum8), 16'h0);

        // WIDTH=1 exhaustive truth table against the classic table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            step(1, 1, {7'h0, abc[2]}, {7'h0, abc[1]}, abc[0]);
            chk("tt_const", 16'({carry1, sum1}), 16'(tt[i]));
        end

        // Hold: result of 1+0+1, then in_valid=0 with different operands.
        step(1, 1, 8'h01, 8'h00, 1);
        step(1, 0, 8'h01, 8'h01, 1);
        chk("hold_const", 16'({ov1, carry1, sum1}), 16'b010);

        // Ripple boundaries at WIDTH=8.
        step(1, 1, 8'hFF, 8'h00, 1);
        chk("ripple_ff", 16'({carry8, sum8}), 16'h100);
        step(1, 1, 8'h7F, 8'h01, 0);
        chk("ripple_7f", 16'({carry8, sum8}), 16'h080);
        step(1, 1, 8'hFF, 8'hFF, 1);
        chk("all_ones", 16'({carry8, sum8}), 16'h1FF);
        step(1, 1, 8'h00, 8'h00, 0);
        chk("all_zeros", 16'({ov8, carry8, sum8}), 16'h200);

        // Back-to-back.
        step(1, 1, 8'h12, 8'h34, 0);
        chk("b2b_0", 16'({ov8, carry8, sum8}), 16'h246);
        step(1, 1, 8'hF0, 8'h20, 1);
        chk("b2b_1", 16'({ov8, carry8, sum8}), 16'h311);

        // Mid-stream reset right after a valid input.
        step(1, 1, 8'hAA, 8'h55, 1);
        step(0, 1, 8'h33, 8'h44, 1);
        chk("mid_rst", 16'({ov8, carry8, sum8}), 16'h000);
        step(1, 1, 8'h10, 8'h20, 1);
        chk("resume", 16'({ov8, carry8, sum8}), 16'h231);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
                 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder. Adds operands a and b plus carry-in c, producing sum and carry-out.
- Used as the arithmetic leaf cell in the datapath. Instantiated standalone (WIDTH=1) or as a ripple-carry adder (WIDTH>1).
- Outputs are registered on clk. A valid qualifier travels alongside the data.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands a, b, c are valid this cycle.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- c  input  1  carry-in.
- out_valid  output  1  sum/carry hold the result of an accepted operation.
- sum  output  WIDTH  registered sum, a + b + c modulo 2^WIDTH.
- carry  output  1  registered carry-out, bit WIDTH of a + b + c.

Behaviour:
- Reset: while rst_n=0 at a rising edge, sum <= 0, carry <= 0 and out_valid <= 0. Reset overrides in_valid in the same cycle.
- Arithmetic:
  - {carry, sum} = a + b + c, computed at WIDTH+1 bits with no overflow loss.
  - Per bit i: s_i = a_i ^ b_i ^ k_i and k_(i+1) = (a_i & b_i) | (a_i & k_i) | (b_i & k_i), where k_0 = c and carry = k_WIDTH.
- Latency: exactly 1 cycle. Operands sampled at edge N with in_valid=1 appear on sum/carry after edge N, with out_valid=1.
- Hold: when in_valid=0 at an edge, sum/carry keep their previous values and out_valid <= 0.
- Throughput: one operation per cycle, no backpressure, no stall. Back-to-back valid inputs yield back-to-back valid outputs.
- Combinational path: the adder chain is purely combinational from the input ports to the output registers. No latches and no combinational path from inputs to outputs.
- X-handling: out_valid is never X after reset. Operand values while in_valid=0 do not affect outputs.
- Reset mid-stream: an operation accepted in the same cycle that rst_n=0 is discarded; the next cycle shows out_valid=0 and zeroed outputs.
- Boundaries:
  - All-ones operands with c=1 give sum = all ones and carry = 1.
  - All-zeros operands with c=0 give sum = 0 and carry = 0.
  - For WIDTH=1 the block is a registered classic 1-bit full adder.

Decomposition:
- No shared package is needed. WIDTH is the only constant and stays a local parameter of the block.
- One sub-module, full_adder_bit: a purely combinational 1-bit cell with inputs a, b, cin and outputs s, cout.
- full_adder instantiates WIDTH copies in a generate loop, chaining each cout to the next cin, and registers the final {carry, sum} together with out_valid.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=1, b=1, c=1 -> sum=0, carry=0, out_valid=0. Release rst_n; the first valid result appears 1 cycle later.
- Exhaustive WIDTH=1 truth table, stepping {a,b,c} from 000 to 111 one per cycle with in_valid=1. Required outputs one cycle later:
  - 000 -> sum=0, carry=0; 001 -> 1,0; 010 -> 1,0; 011 -> 0,1.
  - 100 -> 1,0; 101 -> 0,1; 110 -> 0,1; 111 -> 1,1.
- Hold: after the result a=1, b=0, c=1 (sum=0, carry=1), drive in_valid=0 with a=1, b=1, c=1 -> sum=0, carry=1 unchanged, out_valid=0.
- Ripple at WIDTH=8: a=0xFF, b=0x00, c=1 -> sum=0x00, carry=1. a=0x7F, b=0x01, c=0 -> sum=0x80, carry=0.
- Back-to-back at WIDTH=8: a=0x12, b=0x34, c=0 then a=0xF0, b=0x20, c=1 on consecutive cycles -> outputs 0x46/0 then 0x11/1 on consecutive cycles, out_valid held at 1.
- Mid-stream reset: assert rst_n=0 in the cycle after a valid input -> the next cycle shows out_valid=0, sum=0, carry=0. Normal operation resumes after rst_n=1.
